// File: rtl/ucode_pkg.sv
// Shared constants and word layout for the two-address microcode sequencer.
// The ROM word is {sel, na_f, na_t, ctrl}, from MSB down to LSB.
package ucode_pkg;

  localparam int AW    = 3;
  localparam int CW    = 3;
  localparam int SW    = 2;
  localparam int DW    = SW + 2*AW + CW;
  localparam int NCOND = 2**SW;

  localparam int SEL_MSB  = DW - 1;
  localparam int NAF_MSB  = CW + 2*AW - 1;
  localparam int NAT_MSB  = CW + AW - 1;
  localparam int CTRL_MSB = CW - 1;

  typedef enum logic [SW-1:0] {
    SEL_C0 = 2'd0,
    SEL_C1 = 2'd1,
    SEL_C2 = 2'd2,
    SEL_C3 = 2'd3
  } sel_e;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [AW-1:0] na_f;
    logic [AW-1:0] na_t;
    logic [CW-1:0] ctrl;
  } ucode_word_t;

endpackage

// File: rtl/ucode_sequencer_next_addr.sv
// Next-address select: the condition picked by sel chooses the true or false target.
module ucode_next_addr
  import ucode_pkg::*;
(
  input  logic [SW-1:0]    sel,
  input  logic [AW-1:0]    na_f,
  input  logic [AW-1:0]    na_t,
  input  logic [NCOND-1:0] cond_in,
  output logic [AW-1:0]    nxt
);

  logic c;

  assign c   = cond_in[sel];
  assign nxt = c ? na_t : na_f;

endmodule

// File: rtl/ucode_sequencer.sv
// Micro-PC register, ROM addressing, control gating, done pulse and watchdog recovery.
// Any run away from START_ADDR longer than TIMEOUT enabled cycles is forced home and flagged.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter logic [AW-1:0] START_ADDR = '0,
  parameter int            TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCOND-1:0] cond_in,
  input  logic             err_clr,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic [CW-1:0]    ctrl_out,
  output logic [AW-1:0]    upc_dbg,
  output logic             done,
  output logic             err
);

  localparam bit             WD_ON   = (TIMEOUT > 0);
  localparam int             WDW     = WD_ON ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [WDW-1:0] WD_LAST = WD_ON ? WDW'(TIMEOUT - 1) : '0;

  ucode_word_t    word;
  logic [AW-1:0]  upc_reg;
  logic [WDW-1:0] wd_cnt_reg;
  logic           done_reg;
  logic           err_reg;
  logic [AW-1:0]  nxt;
  logic           away;
  logic           trip;

  assign word = ucode_word_t'(rom_data);

  ucode_next_addr u_next_addr (
    .sel     (word.sel),
    .na_f    (word.na_f),
    .na_t    (word.na_t),
    .cond_in (cond_in),
    .nxt     (nxt)
  );

  assign away = (upc_reg != START_ADDR);
  assign trip = WD_ON && en && away && (wd_cnt_reg == WD_LAST);

  assign rom_addr = upc_reg;
  assign upc_dbg  = upc_reg;
  assign ctrl_out = (en && !rst) ? word.ctrl : '0;
  assign done     = done_reg;
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_reg    <= START_ADDR;
      wd_cnt_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= en && !trip && away && (nxt == START_ADDR);
      if (en) begin
        upc_reg <= trip ? START_ADDR : nxt;
      end
      // The counter measures time away from home, so it restarts whenever we sit there.
      if (trip || !away) begin
        wd_cnt_reg <= '0;
      end else if (en) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (trip) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench: two sequencers (TIMEOUT=6 and TIMEOUT=0) on the ROM8_11 program, checked every
// cycle against a behavioural model, plus hand-computed literal expectations.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  cond = 4'b0000;
  logic        clr = 1'b0;

  logic [2:0]  rom_addr_a, rom_addr_b, ctrl_a, ctrl_b, upc_a, upc_b;
  logic [10:0] rom_data_a, rom_data_b;
  logic        done_a, done_b, err_a, err_b;

  logic [10:0] rom [8];

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // model state, index 0 = TIMEOUT 6, index 1 = TIMEOUT 0
  int to_m   [2] = '{6, 0};
  int m_upc  [2];
  int m_away [2];
  bit m_done [2];
  bit m_err  [2];

  always #5 clk = ~clk;

  assign rom_data_a = rom[rom_addr_a];
  assign rom_data_b = rom[rom_addr_b];

  ucode_sequencer #(.START_ADDR(3'd0), .TIMEOUT(6)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cond_in(cond), .err_clr(clr),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .ctrl_out(ctrl_a),
    .upc_dbg(upc_a), .done(done_a), .err(err_a)
  );

  ucode_sequencer #(.START_ADDR(3'd0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cond_in(cond), .err_clr(clr),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ctrl_out(ctrl_b),
    .upc_dbg(upc_b), .done(done_b), .err(err_b)
  );

  function automatic logic [10:0] mk(input int sel, input int naf, input int nat, input int ctrl);
    logic [10:0] w;
    w = {2'(sel), 3'(naf), 3'(nat), 3'(ctrl)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock of the sequencer's rules, applied to the model with the inputs held this cycle.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic [10:0] w;
      int nxt;
      bit c, trip;
      w = rom[m_upc[i]];
      c = cond[w[10:9]];
      nxt = c ? int'(w[5:3]) : int'(w[8:6]);
      trip = (to_m[i] > 0) && en && (m_upc[i] != 0) && (m_away[i] == to_m[i] - 1);
      if (rst) begin
        m_upc[i] = 0; m_away[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end else if (!en) begin
        m_done[i] = 0;
        if (m_upc[i] == 0) m_away[i] = 0;
        if (clr) m_err[i] = 0;
      end else if (trip) begin
        m_upc[i] = 0; m_away[i] = 0; m_done[i] = 0; m_err[i] = 1;
      end else begin
        m_done[i] = (m_upc[i] != 0) && (nxt == 0);
        m_away[i] = (m_upc[i] != 0) ? m_away[i] + 1 : 0;
        m_upc[i]  = nxt;
        if (clr) m_err[i] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        logic [2:0] exp_ctrl;
        exp_ctrl = (en && !rst) ? rom[m_upc[i]][2:0] : 3'b000;
        chk($sformatf("upc[%0d]", i),      (i == 0) ? upc_a : upc_b,           m_upc[i]);
        chk($sformatf("rom_addr[%0d]", i), (i == 0) ? rom_addr_a : rom_addr_b, m_upc[i]);
        chk($sformatf("ctrl[%0d]", i),     (i == 0) ? ctrl_a : ctrl_b,         exp_ctrl);
        chk($sformatf("done[%0d]", i),     (i == 0) ? done_a : done_b,         m_done[i]);
        chk($sformatf("err[%0d]", i),      (i == 0) ? err_a : err_b,           m_err[i]);
      end
    end
  end

  task automatic step(input logic e, input logic r, input logic [3:0] c, input logic cl);
    en = e; rst = r; cond = c; clr = cl;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rom[0] = mk(0, 0, 1, 3'b000);
    rom[1] = mk(0, 2, 2, 3'b100);
    rom[2] = mk(1, 3, 0, 3'b000);
    rom[3] = mk(2, 2, 4, 3'b001);
    rom[4] = mk(0, 2, 2, 3'b010);
    rom[5] = '0; rom[6] = '0; rom[7] = '0;
    for (int i = 0; i < 2; i++) begin
      m_upc[i] = 0; m_away[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end

    // start/step
    step(1, 1, 4'b0000, 0);
    checking = 1'b1;
    chk("lit_reset_upc", upc_a, 0);
    chk("lit_reset_err", err_a, 0);
    repeat (3) step(1, 0, 4'b0000, 0);
    chk("lit_idle_upc", upc_a, 0);
    step(1, 0, 4'b0001, 0);
    chk("lit_step1_upc", upc_a, 1);
    chk("lit_step1_ctrl", ctrl_a, 3'b100);
    step(1, 0, 4'b0000, 0);
    chk("lit_step2_upc", upc_a, 2);
    // return/done
    step(1, 0, 4'b0010, 0);
    chk("lit_ret_upc", upc_a, 0);
    chk("lit_ret_done", done_a, 1);
    step(1, 0, 4'b0000, 0);
    chk("lit_done_once", done_a, 0);
    step(1, 0, 4'b0001, 0);
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    chk("lit_no_ret_upc", upc_a, 3);
    chk("lit_no_ret_ctrl", ctrl_a, 3'b001);
    chk("lit_no_ret_done", done_a, 0);
    // stall, then branch taken, then reset mid-run
    repeat (3) step(0, 0, 4'b0100, 0);
    chk("lit_stall_upc", upc_a, 3);
    chk("lit_stall_ctrl", ctrl_a, 3'b000);
    step(1, 0, 4'b0100, 0);
    chk("lit_branch_upc", upc_a, 4);
    chk("lit_branch_ctrl", ctrl_a, 3'b010);
    step(1, 1, 4'b0100, 0);
    chk("lit_rst_upc", upc_a, 0);
    chk("lit_rst_done", done_a, 0);
    // branch not taken: 0,1,2,3,2
    step(1, 0, 4'b0001, 0);
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    chk("lit_notaken_upc", upc_a, 2);
    step(1, 1, 4'b0000, 0);
    // watchdog: 1,2,3,4,2,3 then forced home
    begin
      int seq [7] = '{1, 2, 3, 4, 2, 3, 0};
      for (int k = 0; k < 7; k++) begin
        step(1, 0, 4'b0101, 0);
        chk($sformatf("lit_wd_seq%0d", k), upc_a, seq[k]);
        chk($sformatf("lit_wd_nodone%0d", k), done_a, 0);
      end
    end
    chk("lit_wd_err", err_a, 1);
    chk("lit_wd_b_err", err_b, 0);
    step(1, 0, 4'b0101, 1);
    chk("lit_clr_err", err_a, 0);
    repeat (5) step(1, 0, 4'b0101, 0);
    chk("lit_pretrip_upc", upc_a, 3);
    step(1, 0, 4'b0101, 1);
    chk("lit_trip_clr_err", err_a, 1);
    chk("lit_trip_clr_upc", upc_a, 0);
    // watchdog disabled instance keeps looping 2,3,4
    repeat (100) step(1, 0, 4'b0101, 0);
    chk("lit_nowd_err", err_b, 0);
    chk("lit_nowd_range", (upc_b >= 2 && upc_b <= 4), 1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3,
           4'($urandom), $urandom_range(0, 99) < 10);
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
